i2c_req_arbiter: RTL and testbench

I2C_REQ_ARBITER -- requirements
Module: i2c_req_arbiter

---
 rtl/i2c_req_arbiter.sv | 176 +++++++++++++++++
 tb/tb_i2c_req_arbiter.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_req_arbiter.sv
// Round-robin arbiter that lets NREQ requesters share one I2C master, one transaction at a
// time, with a per-transaction watchdog. Every output is a register.
module i2c_req_arbiter #(
   parameter int NREQ      = 4,
   parameter int TO_CYCLES = 1023
) (
   input  logic              sys_clk,
   input  logic              rst,
   input  logic [NREQ-1:0]   req_valid,
   input  logic [NREQ*8-1:0] req_addr,
   input  logic [NREQ*8-1:0] req_data,
   input  logic [NREQ-1:0]   req_wr,
   output logic [NREQ-1:0]   req_ready,
   output logic [NREQ-1:0]   rsp_valid,
   output logic [7:0]        rsp_rdata,
   output logic              rsp_err,
   output logic              m_run,
   output logic [7:0]        m_addr,
   output logic [7:0]        m_data,
   output logic              m_wr_bit,
   input  logic              m_busy,
   input  logic              m_done,
   input  logic              m_ack_err,
   input  logic [7:0]        m_rdata,
   output logic              busy,
   output logic [2:0]        dbg_state
);
   localparam int IW  = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int WDW = $clog2(TO_CYCLES + 1);
   localparam logic [WDW-1:0] TO_LIM = WDW'(TO_CYCLES);

   typedef enum logic [2:0] {IDLE, GRANT, ISSUE, WAIT, RESP} state_t;

   state_t          state, state_n;
   logic [IW-1:0]   g, g_n;
   logic [IW-1:0]   ptr, ptr_n;
   logic [WDW-1:0]  wd, wd_n, wd_inc;
   logic            timeout;
   logic [IW-1:0]   sel_idx;
   logic            sel_found;
   logic [NREQ-1:0] sel_onehot, g_onehot;
   logic [NREQ-1:0] req_ready_n, rsp_valid_n;
   logic            m_run_n, m_wr_n, err_n, busy_n;
   logic [7:0]      m_addr_n, m_data_n, rdata_n;
   logic [7:0]      addr_arr [NREQ];
   logic [7:0]      data_arr [NREQ];

   // Handshake: requester i holds req_valid[i] and its payload until it sees the one-cycle
   // req_ready[i]; the payload is taken at the end of that cycle. Each accepted request gets
   // exactly one rsp_valid[i] pulse, unless a reset drops the transaction first.

   for (genvar i = 0; i < NREQ; i++) begin : g_unpack
      assign addr_arr[i] = req_addr[8*i +: 8];
      assign data_arr[i] = req_data[8*i +: 8];
   end

   // First requesting index at or above ptr, wrapping around.
   always_comb begin
      int            idx;
      logic [IW-1:0] cand;
      idx       = 0;
      cand      = '0;
      sel_found = 1'b0;
      sel_idx   = '0;
      for (int k = 0; k < NREQ; k++) begin
         idx = int'(ptr) + k;
         if (idx >= NREQ) idx = idx - NREQ;
         cand = IW'(idx);
         if (!sel_found && req_valid[cand]) begin
            sel_found = 1'b1;
            sel_idx   = cand;
         end
      end
   end

   always_comb begin
      sel_onehot          = '0;
      sel_onehot[sel_idx] = 1'b1;
      g_onehot            = '0;
      g_onehot[g]         = 1'b1;
   end

   // wd counts cycles since GRANT, so timeout lands RESP exactly TO_CYCLES cycles after GRANT.
   assign wd_inc  = wd + 1'b1;
   assign timeout = (wd_inc == TO_LIM);

   always_comb begin
      state_n     = state;
      g_n         = g;
      ptr_n       = ptr;
      wd_n        = wd;
      req_ready_n = '0;
      rsp_valid_n = '0;
      m_run_n     = 1'b0;
      m_addr_n    = m_addr;
      m_data_n    = m_data;
      m_wr_n      = m_wr_bit;
      rdata_n     = rsp_rdata;
      err_n       = rsp_err;
      case (state)
         IDLE: begin
            if (|req_valid) begin
               state_n     = GRANT;
               g_n         = sel_idx;
               wd_n        = '0;
               req_ready_n = sel_onehot;
            end
         end
         GRANT: begin
            m_addr_n = addr_arr[g];
            m_data_n = data_arr[g];
            m_wr_n   = req_wr[g];
            ptr_n    = (int'(g) == NREQ - 1) ? '0 : g + 1'b1;
            wd_n     = wd_inc;
            m_run_n  = 1'b1;
            state_n  = ISSUE;
         end
         ISSUE, WAIT: begin
            wd_n = wd_inc;
            if (m_done) begin
               rdata_n     = m_rdata;
               err_n       = m_ack_err;
               rsp_valid_n = g_onehot;
               state_n     = RESP;
            end else if (timeout) begin
               rdata_n     = 8'h00;
               err_n       = 1'b1;
               rsp_valid_n = g_onehot;
               state_n     = RESP;
            end else if (state == ISSUE && !m_busy) begin
               m_run_n = 1'b1;
            end else begin
               state_n = WAIT;
            end
         end
         RESP:    state_n = IDLE;
         default: state_n = IDLE;
      endcase
      busy_n = (state_n != IDLE);
   end

   always_ff @(posedge sys_clk) begin
      if (rst) begin
         state     <= IDLE;
         g         <= '0;
         ptr       <= '0;
         wd        <= '0;
         req_ready <= '0;
         rsp_valid <= '0;
         m_run     <= 1'b0;
         m_addr    <= 8'h00;
         m_data    <= 8'h00;
         m_wr_bit  <= 1'b0;
         rsp_rdata <= 8'h00;
         rsp_err   <= 1'b0;
         busy      <= 1'b0;
      end else begin
         state     <= state_n;
         g         <= g_n;
         ptr       <= ptr_n;
         wd        <= wd_n;
         req_ready <= req_ready_n;
         rsp_valid <= rsp_valid_n;
         m_run     <= m_run_n;
         m_addr    <= m_addr_n;
         m_data    <= m_data_n;
         m_wr_bit  <= m_wr_n;
         rsp_rdata <= rdata_n;
         rsp_err   <= err_n;
         busy      <= busy_n;
      end
   end

   assign dbg_state = state;

endmodule

// File: tb/tb_i2c_req_arbiter.sv
// Randomized self-checking bench for i2c_req_arbiter: a transaction-level model predicts
// grant order, latencies and responses; a scoreboard queue holds the expected responses.
module tb_i2c_req_arbiter;
   localparam int NREQ      = 4;
   localparam int TO_CYCLES = 40;

   logic              sys_clk;
   logic              rst;
   logic [NREQ-1:0]   req_valid, req_wr, req_ready, rsp_valid;
   logic [NREQ*8-1:0] req_addr, req_data;
   logic [7:0]        rsp_rdata, m_addr, m_data, m_rdata;
   logic              rsp_err, m_run, m_wr_bit, m_busy, m_done, m_ack_err, busy;
   logic [2:0]        dbg_state;

   int          checks = 0;
   int          failures = 0;
   logic [15:0] exp_q[$];
   int          model_ptr;
   logic [NREQ-1:0] pending;
   logic [7:0]  pend_addr [NREQ];
   logic [7:0]  pend_data [NREQ];
   logic        pend_wr   [NREQ];
   logic [7:0]  last_rdata;
   logic        last_err;
   logic        arrivals_on;

   i2c_req_arbiter #(.NREQ(NREQ), .TO_CYCLES(TO_CYCLES)) dut (
      .sys_clk   (sys_clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_addr  (req_addr),
      .req_data  (req_data),
      .req_wr    (req_wr),
      .req_ready (req_ready),
      .rsp_valid (rsp_valid),
      .rsp_rdata (rsp_rdata),
      .rsp_err   (rsp_err),
      .m_run     (m_run),
      .m_addr    (m_addr),
      .m_data    (m_data),
      .m_wr_bit  (m_wr_bit),
      .m_busy    (m_busy),
      .m_done    (m_done),
      .m_ack_err (m_ack_err),
      .m_rdata   (m_rdata),
      .busy      (busy),
      .dbg_state (dbg_state)
   );

   // clock / reset
   initial sys_clk = 1'b0;
   always #5 sys_clk = ~sys_clk;

   task automatic tick();
      @(negedge sys_clk);
   endtask

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // reference model helpers
   function automatic int rr_pick(input logic [NREQ-1:0] mask, input int ptr);
      for (int k = 0; k < NREQ; k++)
         if (mask[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
      return 0;
   endfunction

   function automatic int onehot_idx(input logic [NREQ-1:0] v);
      int idx = -1;
      int cnt = 0;
      for (int i = 0; i < NREQ; i++)
         if (v[i]) begin
            idx = i;
            cnt++;
         end
      return (cnt == 1) ? idx : -1;
   endfunction

   // drivers
   task automatic drive_reqs();
      for (int i = 0; i < NREQ; i++) begin
         req_valid[i]       = pending[i];
         req_addr[8*i +: 8] = pend_addr[i];
         req_data[8*i +: 8] = pend_data[i];
         req_wr[i]          = pend_wr[i];
      end
   endtask

   task automatic add_req(input int i, input logic [7:0] a, input logic [7:0] d, input logic w);
      pending[i]   = 1'b1;
      pend_addr[i] = a;
      pend_data[i] = d;
      pend_wr[i]   = w;
      drive_reqs();
   endtask

   task automatic random_arrival();
      int i;
      i = $urandom_range(0, NREQ - 1);
      if (!pending[i]) add_req(i, 8'($urandom), 8'($urandom), 1'($urandom));
   endtask

   task automatic apply_reset();
      rst       = 1'b1;
      m_busy    = 1'b0;
      m_done    = 1'b0;
      m_ack_err = 1'b0;
      m_rdata   = 8'h00;
      pending   = '0;
      for (int i = 0; i < NREQ; i++) begin
         pend_addr[i] = 8'h00;
         pend_data[i] = 8'h00;
         pend_wr[i]   = 1'b0;
      end
      drive_reqs();
      repeat (3) tick();
      rst        = 1'b0;
      model_ptr  = 0;
      last_rdata = 8'h00;
      last_err   = 1'b0;
      exp_q.delete();
   endtask

   // Called at a negedge with the DUT in IDLE and at least one request pending.
   // mode 0: done in ISSUE without busy; 1: busy then done after dly cycles; 2: never done.
   task automatic serve_one(input int mode, input int dly, input logic [7:0] rd,
                            input logic ack, output int obs);
      int          g, n, k;
      logic [7:0]  a, d;
      logic        w;
      logic [15:0] exp_e;
      g = rr_pick(pending, model_ptr);
      n = 0;
      do begin
         tick();
         n++;
      end while (req_ready == '0 && n < 20);
      obs = onehot_idx(req_ready);
      check("grant_idx", obs, g);
      check("ready_latency", n, 1);
      check("busy_grant", busy, 1);
      check("rsp_rdata_hold", rsp_rdata, last_rdata);
      check("rsp_err_hold", rsp_err, last_err);
      a = pend_addr[g];
      d = pend_data[g];
      w = pend_wr[g];
      pending[g] = 1'b0;
      drive_reqs();
      model_ptr = (g + 1) % NREQ;
      if (mode == 2) exp_e = {3'b000, 4'(g), 1'b1, 8'h00};
      else           exp_e = {3'b000, 4'(g), ack, rd};
      exp_q.push_back(exp_e);
      tick();
      check("m_run_issue", m_run, 1);
      check("m_addr", m_addr, a);
      check("m_data", m_data, d);
      check("m_wr_bit", m_wr_bit, w);
      if (arrivals_on && $urandom_range(0, 2) == 0) random_arrival();
      k = 1;
      case (mode)
         0: begin
            m_done = 1'b1; m_rdata = rd; m_ack_err = ack;
            tick();
            m_done = 1'b0; m_rdata = 8'($urandom); m_ack_err = 1'($urandom);
         end
         1: begin
            m_busy = 1'b1;
            tick();
            check("m_run_wait", m_run, 0);
            repeat (dly) tick();
            m_done = 1'b1; m_busy = 1'b0; m_rdata = rd; m_ack_err = ack;
            tick();
            m_done = 1'b0; m_rdata = 8'($urandom); m_ack_err = 1'($urandom);
         end
         default: begin
            m_busy = 1'b1;
            while (rsp_valid == '0 && k < TO_CYCLES + 10) begin
               tick();
               k++;
            end
            check("timeout_latency", k, TO_CYCLES);
            m_busy = 1'b0;
         end
      endcase
      exp_e = exp_q.pop_front();
      check("rsp_valid", rsp_valid, 32'd1 << exp_e[12:9]);
      check("rsp_payload", {rsp_err, rsp_rdata}, exp_e[8:0]);
      last_rdata = exp_e[7:0];
      last_err   = exp_e[8];
      tick();
      check("rsp_one_cycle", rsp_valid, 0);
      check("busy_idle", busy, 0);
   endtask

   int obs;
   int n;
   int seen;
   int rr_exp [5] = '{0, 1, 2, 3, 0};
   logic [NREQ-1:0] mask;

   initial begin
      arrivals_on = 1'b0;
      apply_reset();
      check("rst_ctrl", {req_ready, rsp_valid, m_run, m_wr_bit, rsp_err, busy}, 0);
      check("rst_data", {m_addr, m_data, rsp_rdata}, 0);

      // single write to requester 0
      add_req(0, 8'hFF, 8'h12, 1'b1);
      serve_one(1, 2, 8'h00, 1'b0, obs);
      // read with NACK on requester 2
      add_req(2, 8'h48, 8'h00, 1'b0);
      serve_one(1, 3, 8'hA5, 1'b1, obs);
      // done while still in ISSUE
      add_req(3, 8'h30, 8'h00, 1'b0);
      serve_one(0, 0, 8'h5E, 1'b0, obs);
      // watchdog expiry
      add_req(1, 8'h77, 8'h01, 1'b1);
      serve_one(2, 0, 8'h99, 1'b0, obs);

      // stray m_done while idle must be ignored
      m_done = 1'b1; m_rdata = 8'h3C; m_ack_err = 1'b0;
      tick();
      m_done = 1'b0;
      tick();
      check("idle_done_rsp", rsp_valid, 0);
      check("idle_done_rdata", rsp_rdata, last_rdata);
      check("idle_done_busy", busy, 0);

      // round-robin with every requester asking, requester 0 re-requesting
      apply_reset();
      for (int i = 0; i < NREQ; i++) add_req(i, 8'($urandom), 8'($urandom), 1'($urandom));
      for (int t = 0; t < 5; t++) begin
         serve_one(t % 2, 1, 8'($urandom), 1'b0, obs);
         check("rr_order", obs, rr_exp[t]);
         if (t == 0) add_req(0, 8'($urandom), 8'($urandom), 1'($urandom));
      end

      // reset while waiting on the master
      add_req(1, 8'h21, 8'h77, 1'b1);
      n = 0;
      do begin
         tick();
         n++;
      end while (req_ready == '0 && n < 20);
      check("pre_rst_grant", req_ready, 32'd1 << 1);
      pending[1] = 1'b0;
      drive_reqs();
      tick();
      m_busy = 1'b1;
      tick();
      tick();
      rst = 1'b1;
      tick();
      check("mid_rst_ctrl", {req_ready, rsp_valid, m_run, m_wr_bit, rsp_err, busy}, 0);
      check("mid_rst_data", {m_addr, m_data, rsp_rdata}, 0);
      rst    = 1'b0;
      m_busy = 1'b0;
      seen   = 0;
      repeat (6) begin
         tick();
         if (rsp_valid != '0) seen = 1;
      end
      check("no_rsp_after_rst", seen, 0);
      model_ptr  = 0;
      last_rdata = 8'h00;
      last_err   = 1'b0;
      add_req(0, 8'h10, 8'h20, 1'b1);
      add_req(2, 8'h11, 8'h22, 1'b0);
      serve_one(1, 1, 8'h00, 1'b0, obs);
      check("grant_after_rst", obs, 0);
      serve_one(0, 0, 8'hC3, 1'b0, obs);

      // randomized traffic
      arrivals_on = 1'b1;
      for (int it = 0; it < 40; it++) begin
         int r;
         if (pending == '0) begin
            mask = NREQ'($urandom_range(1, (1 << NREQ) - 1));
            for (int i = 0; i < NREQ; i++)
               if (mask[i]) add_req(i, 8'($urandom), 8'($urandom), 1'($urandom));
         end
         r = $urandom_range(0, 9);
         serve_one((r < 3) ? 0 : (r < 9) ? 1 : 2, $urandom_range(0, 6),
                   8'($urandom), 1'($urandom), obs);
      end
      arrivals_on = 1'b0;

      check("scoreboard_empty", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
